// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with a TX FIFO, programmable baud divider and a sticky EXIT register.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data bits and STOP.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR     = 32'h02000000,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] RESET_BAUDDIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        sim_exit,
    output logic [31:0] exit_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic [15:0]   cur_div;
    logic [15:0]   baud_div;
    logic          overflow;
    logic          bit_end;
    logic          busy;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    logic          sel;
    logic [1:0]    offset;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic          wr_exit;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   status_word;

    logic          unused_adr;
    assign unused_adr = ^DataAdr[1:0];

    assign sel       = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign offset    = DataAdr[3:2];
    assign wr_txdata = MemWrite && sel && (offset == 2'd0);
    assign wr_status = MemWrite && sel && (offset == 2'd1);
    assign wr_baud   = MemWrite && sel && (offset == 2'd2);
    assign wr_exit   = MemWrite && sel && (offset == 2'd3);

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_txdata && !full;
    assign pop     = (state == IDLE) && !empty;
    assign busy    = (state != IDLE);
    assign bit_end = (baud_cnt == cur_div - 16'd1);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A write that finds the FIFO full is lost even if a pop frees a slot in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            baud_div  <= RESET_BAUDDIV;
            sim_exit  <= 1'b0;
            exit_code <= '0;
        end else begin
            if (wr_status) begin
                overflow <= 1'b0;
            end else if (wr_txdata && full) begin
                overflow <= 1'b1;
            end
            if (wr_baud) begin
                baud_div <= (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
            end
            if (wr_exit) begin
                sim_exit  <= 1'b1;
                exit_code <= WriteData;
            end
        end
    end

    // The divider is sampled at pop so a BAUDDIV write never disturbs a frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            cur_div  <= RESET_BAUDDIV;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        state    <= START;
                        tx       <= 1'b0;
                        shift    <= fifo_mem[rd_ptr];
                        cur_div  <= baud_div;
                        baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_mem[rd_ptr];
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        tx       <= shift[0];
                        shift    <= shift >> 1;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        status_word            = '0;
        status_word[16 +: CW]  = count;
        status_word[3]         = overflow;
        status_word[2]         = empty;
        status_word[1]         = full;
        status_word[0]         = busy;
    end

    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (offset)
                2'd1:    ReadData = status_word;
                2'd2:    ReadData = {16'd0, baud_div};
                2'd3:    ReadData = exit_code;
                default: ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx; frames are checked bit cell by bit cell.
module tb_mmio_uart_tx;

    localparam logic [31:0] TXDATA_ADR = 32'h02000000;
    localparam logic [31:0] STATUS_ADR = 32'h02000004;
    localparam logic [31:0] BAUD_ADR   = 32'h02000008;
    localparam logic [31:0] EXIT_ADR   = 32'h0200000C;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        MemWrite  = 1'b0;
    logic [31:0] DataAdr   = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        tx;
    logic        sim_exit;
    logic [31:0] exit_code;

    int tests    = 0;
    int failures = 0;

    logic [7:0]  vec [9];
    logic [31:0] rd;
    logic [31:0] rdB;

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .sim_exit  (sim_exit),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] data);
        DataAdr   = adr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] adr, output logic [31:0] data);
        DataAdr = adr;
        #1;
        data = ReadData;
    endtask

    task automatic nextSample;
        @(posedge clk);
        #2;
    endtask

    // Entered on the first START sample; leaves on the sample right after STOP.
    task automatic checkFrame(input string name, input logic [7:0] b, input int div, input bit chkBusy);
        int   cells;
        int   txOk;
        int   busyOk;
        logic expBit;
        cells = PAR ? 11 : 10;
        for (int k = 0; k < cells; k++) begin
            if (k == 0)              expBit = 1'b0;
            else if (k <= 8)         expBit = b[k-1];
            else if (k == cells - 1) expBit = 1'b1;
            else                     expBit = ^b;
            txOk   = 0;
            busyOk = 0;
            for (int j = 0; j < div; j++) begin
                if (tx === expBit) txOk++;
                if (ReadData[0] === 1'b1) busyOk++;
                nextSample();
            end
            checkOutput($sformatf("%s_cell%0d", name, k), 32'(txOk), 32'(div));
            if (chkBusy) checkOutput($sformatf("%s_busy%0d", name, k), 32'(busyOk), 32'(div));
        end
    endtask

    initial begin
        int quietOk;
        for (int i = 0; i < 9; i++) vec[i] = 8'((i + 1) * 17);

        // Reset state while reset is held low
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_sim_exit", 32'(sim_exit), 32'd0);
        checkOutput("rst_exit_code", exit_code, 32'd0);
        readReg(STATUS_ADR, rd);
        checkOutput("rst_status", rd, 32'h00000004);
        readReg(BAUD_ADR, rd);
        checkOutput("rst_baud", rd, 32'd16);
        reset = 1'b1;
        nextSample();

        // Accesses outside the window are ignored
        applyStimulus(32'h03000000, 32'h000000AA);
        readReg(32'h03000004, rd);
        checkOutput("unsel_read", rd, 32'd0);
        readReg(STATUS_ADR, rd);
        checkOutput("unsel_status", rd, 32'h00000004);

        // BAUDDIV of zero clamps to one
        applyStimulus(BAUD_ADR, 32'd0);
        readReg(BAUD_ADR, rd);
        checkOutput("baud_clamp", rd, 32'd1);

        // Single 0x55 frame at BAUDDIV=4 with busy tracking
        applyStimulus(BAUD_ADR, 32'd4);
        applyStimulus(TXDATA_ADR, 32'h55);
        DataAdr = STATUS_ADR;
        #1;
        checkOutput("pre_start_tx", 32'(tx), 32'd1);
        checkOutput("pre_start_status", ReadData, 32'h00010000);
        nextSample();
        checkFrame("f55", 8'h55, 4, 1'b1);
        checkOutput("post_frame_tx", 32'(tx), 32'd1);
        checkOutput("post_frame_status", ReadData, 32'h00000004);

        // Nine writes while busy: eight queue, the ninth overflows
        applyStimulus(BAUD_ADR, 32'd16);
        applyStimulus(TXDATA_ADR, 32'hA5);
        fork
            begin
                nextSample();
                checkFrame("fA5", 8'hA5, 16, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    checkOutput($sformatf("gap%0d", i), 32'(tx), 32'd1);
                    nextSample();
                    checkFrame($sformatf("fifo%0d", i), vec[i], 16, 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                for (int i = 0; i < 9; i++) applyStimulus(TXDATA_ADR, {24'd0, vec[i]});
                readReg(STATUS_ADR, rdB);
                checkOutput("status_full_ovf", rdB, 32'h0008000B);
            end
        join
        readReg(STATUS_ADR, rd);
        checkOutput("status_drained_ovf", rd, 32'h0000000C);
        applyStimulus(STATUS_ADR, 32'd0);
        readReg(STATUS_ADR, rd);
        checkOutput("status_ovf_cleared", rd, 32'h00000004);

        // BAUDDIV change mid-frame applies to the next frame only
        applyStimulus(BAUD_ADR, 32'd4);
        applyStimulus(TXDATA_ADR, 32'h0F);
        applyStimulus(TXDATA_ADR, 32'hF0);
        #1;
        fork
            checkFrame("old_div", 8'h0F, 4, 1'b0);
            begin
                repeat (10) @(posedge clk);
                #1;
                applyStimulus(BAUD_ADR, 32'h1234);
            end
        join
        checkOutput("div_gap", 32'(tx), 32'd1);
        readReg(BAUD_ADR, rd);
        checkOutput("baud_1234", rd, 32'h1234);
        nextSample();
        checkFrame("new_div", 8'hF0, 32'h1234, 1'b0);

        // EXIT register
        checkOutput("exit_pre", 32'(sim_exit), 32'd0);
        applyStimulus(EXIT_ADR, 32'd1);
        checkOutput("exit_flag1", 32'(sim_exit), 32'd1);
        checkOutput("exit_code1", exit_code, 32'd1);
        applyStimulus(EXIT_ADR, 32'd7);
        checkOutput("exit_flag7", 32'(sim_exit), 32'd1);
        checkOutput("exit_code7", exit_code, 32'd7);
        readReg(EXIT_ADR, rd);
        checkOutput("exit_read", rd, 32'd7);

        // Reset in the middle of data bit 3
        applyStimulus(BAUD_ADR, 32'd4);
        applyStimulus(TXDATA_ADR, 32'h55);
        repeat (18) @(posedge clk);
        #2;
        checkOutput("pre_reset_bit3", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_sim_exit", 32'(sim_exit), 32'd0);
        checkOutput("reset_exit_code", exit_code, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        readReg(STATUS_ADR, rd);
        checkOutput("post_reset_status", rd, 32'h00000004);
        readReg(BAUD_ADR, rd);
        checkOutput("post_reset_baud", rd, 32'd16);
        quietOk = 0;
        for (int i = 0; i < 60; i++) begin
            nextSample();
            if (tx === 1'b1) quietOk++;
        end
        checkOutput("post_reset_quiet", 32'(quietOk), 32'd60);

`ifdef UART_TX_PARITY_EN
        // Even parity for 0x07 (odd ones -> 1) and 0x03 (even ones -> 0)
        applyStimulus(BAUD_ADR, 32'd4);
        applyStimulus(TXDATA_ADR, 32'h07);
        applyStimulus(TXDATA_ADR, 32'h03);
        #1;
        checkFrame("par07", 8'h07, 4, 1'b0);
        checkOutput("par_gap", 32'(tx), 32'd1);
        nextSample();
        checkFrame("par03", 8'h03, 4, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
